ifetch_prefetch_queue: RTL and testbench
========================================

Name: ifetch_prefetch_queue

Overview:
- Fetch-side front end of the 5-stage pipeline. It sits between instruction memory and the IF/ID pipeline register.
- Issues sequential instruction fetches over a req/ack memory handshake and buffers the returned words, with their PCs, in a small FIFO. Decode drains the FIFO under a valid/ready handshake.
- Accepts branch/jump redirects from EX, which flush the FIFO and discard any in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
RESET_PC, 32'h00000000, first fetch address after reset
NOP_INSTR, 32'h00000013, instruction word placed in halt entries (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
redirect_in_if  in  1  EX redirect strobe (taken branch/jump), one-cycle pulse
redirect_target_in_if  in  32  redirect target PC
imem_req_out  out  1  fetch request
imem_addr_out  out  32  fetch address; stable while imem_req_out=1
imem_ack_in  in  1  memory response valid; legal only while imem_req_out=1
imem_data_in  in  32  fetched instruction word, valid with ack
id_ready_in  in  1  decode can accept the head entry
inst_valid_out  out  1  head entry valid
inst_out  out  32  head instruction
pc_out  out  32  head PC
pc4_out  out  32  head PC+4
halt_out  out  1  head entry is a halt marker
queue_count_out  out  $clog2(DEPTH)+1  occupancy (debug/verification)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; FIFO empty; drop flag=0; FSM=IDLE; all outputs 0.
- FSM states:
  - IDLE: if fetch_pc[1:0]≠0, push halt entry {pc=fetch_pc, inst=NOP_INSTR, halt=1} and go to HALTED (push needs count<DEPTH; otherwise stay in IDLE).
  - IDLE: else if count<DEPTH, register imem_req_out=1 and imem_addr_out=fetch_pc, go to WAIT.
  - WAIT: hold req and addr until ack. On ack:
    - if drop=0, push {fetch_pc, imem_data_in, halt=0} and fetch_pc+=4;
    - if drop=1, discard the word and clear drop;
    - drop req and go to IDLE.
  - HALTED: no requests issued. Exits only on redirect or reset.
- At most one outstanding request. Reservation rule: the FSM leaves IDLE only if count<DEPTH, so the pushed word always fits. Back-to-back throughput is one word per 2 cycles (req registered, ack, then IDLE).
- ack is sampled in any cycle req=1, including the first cycle req is high. Minimum latency is ack at cycle t → inst_valid_out=1 at cycle t+1 (no bypass from memory to outputs).
- Output side:
  - Outputs are the FIFO head, registered.
  - inst_valid_out=(count>0).
  - Pop when inst_valid_out & id_ready_in.
  - Push and pop in the same cycle leave count unchanged.
  - pc4_out=pc_out+32'd4 (mod 2^32).
  - Head outputs are stable while valid and not popped.
- Redirect, highest priority, applied at the clock edge:
  - FIFO flushed (count=0). Any same-cycle pop or push is ignored.
  - fetch_pc=redirect_target_in_if.
  - If in WAIT and ack not present this cycle: stay in WAIT, set drop=1, keep req and addr (the old address) until ack.
  - If in WAIT and ack present this cycle: word discarded, go to IDLE, drop=0.
  - From IDLE or HALTED: go to IDLE.
  - inst_valid_out=0 in the cycle after a redirect.
  - A redirect while drop=1 only updates fetch_pc; drop stays 1.
- A misaligned redirect target produces a halt entry on the next IDLE cycle.
- Pointers wrap modulo DEPTH. fetch_pc wraps modulo 2^32.
- Reset mid-request: req drops immediately. An ack arriving after reset release with req=0 is ignored.

Test Plan:
- Reset release, memory acks 1 cycle after each req with data=PC^32'hA5A50000, id_ready_in=1 → requests go to 0x0,0x4,0x8. The first entry {pc=0x0, inst=0xA5A50000, pc4=0x4} is valid 1 cycle after its ack, in order, with no gaps beyond the 2-cycle issue rate.
- id_ready_in=0, DEPTH=4 → exactly 4 requests issued, then req stays 0 and queue_count_out=4. Raise ready for 1 cycle → one pop, one new request to 0x10.
- Redirect to 0x100 while in WAIT for 0x8, ack 3 cycles later with 0xDEADBEEF → the word is not enqueued, FIFO empty. The next req is to 0x100 and the head becomes pc=0x100.
- Redirect in the same cycle as ack and as a pop → FIFO count=0 after the edge, no entry for the acked word. Next req address = target.
- Redirect to 0x102 → no request issued. One entry {pc=0x102, inst=0x00000013, halt_out=1}, then no further requests. A subsequent redirect to 0x200 resumes fetching.
- Assert rst=0 asynchronously mid-WAIT → imem_req_out, inst_valid_out and halt_out are 0 immediately. After release, the first req goes to RESET_PC.

Source files
------------

// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetches over a req/ack handshake
// and buffers returned words with their PCs in a small FIFO drained by decode.
module ifetch_prefetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_in_if,
  input  logic [31:0]              redirect_target_in_if,
  output logic                     imem_req_out,
  output logic [31:0]              imem_addr_out,
  input  logic                     imem_ack_in,
  input  logic [31:0]              imem_data_in,
  input  logic                     id_ready_in,
  output logic                     inst_valid_out,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic [31:0]              pc4_out,
  output logic                     halt_out,
  output logic [$clog2(DEPTH):0]   queue_count_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
  } entry_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc, fetch_pc_next;
  logic [31:0]     req_addr, req_addr_next;
  logic            drop, drop_next;
  entry_t          mem [DEPTH];
  entry_t          head, push_entry;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            ack, has_room, push, pop;

  // An ack is only meaningful while a request is outstanding.
  assign ack      = imem_ack_in & (state == S_WAIT);
  assign has_room = (count < CW'(DEPTH));
  assign pop      = inst_valid_out & id_ready_in & ~redirect_in_if;
  assign head     = mem[rd_ptr];
  assign queue_count_out = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    drop_next     = drop;
    push          = 1'b0;
    push_entry    = '{pc: fetch_pc, inst: NOP_INSTR, halt: 1'b1};

    unique case (state)
      S_IDLE: begin
        if (has_room) begin
          if (fetch_pc[1:0] != 2'b00) begin
            push       = 1'b1;
            state_next = S_HALTED;
          end else begin
            req_addr_next = fetch_pc;
            state_next    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (ack) begin
          if (!drop) begin
            push          = 1'b1;
            push_entry    = '{pc: fetch_pc, inst: imem_data_in, halt: 1'b0};
            fetch_pc_next = fetch_pc + 32'd4;
          end
          drop_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_IDLE;
    endcase

    // Redirect wins over everything; an un-acked request stays on the bus
    // with its old address and its eventual word is thrown away.
    if (redirect_in_if) begin
      push          = 1'b0;
      fetch_pc_next = redirect_target_in_if;
      req_addr_next = req_addr;
      if (state == S_WAIT && !ack) begin
        state_next = S_WAIT;
        drop_next  = 1'b1;
      end else begin
        state_next = S_IDLE;
        drop_next  = 1'b0;
      end
    end
  end

  always_comb begin
    imem_req_out   = (state == S_WAIT);
    imem_addr_out  = req_addr;
    inst_valid_out = (count != '0);
    inst_out       = '0;
    pc_out         = '0;
    pc4_out        = '0;
    halt_out       = 1'b0;
    if (inst_valid_out) begin
      inst_out = head.inst;
      pc_out   = head.pc;
      pc4_out  = head.pc + 32'd4;
      halt_out = head.halt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      drop     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
      drop     <= drop_next;
      if (redirect_in_if) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: storage is left unreset; every head output is masked by inst_valid_out,
  // so stale entries are never visible and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Self-checking bench: a queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_ifetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_in_if = 1'b0;
  logic [31:0] redirect_target_in_if = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 1'b0;
  logic [31:0] imem_data_in = '0;
  logic        id_ready_in = 1'b0;
  logic        inst_valid_out;
  logic [31:0] inst_out, pc_out, pc4_out;
  logic        halt_out;
  logic [2:0]  queue_count_out;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .redirect_in_if        (redirect_in_if),
    .redirect_target_in_if (redirect_target_in_if),
    .imem_req_out          (imem_req_out),
    .imem_addr_out         (imem_addr_out),
    .imem_ack_in           (imem_ack_in),
    .imem_data_in          (imem_data_in),
    .id_ready_in           (id_ready_in),
    .inst_valid_out        (inst_valid_out),
    .inst_out              (inst_out),
    .pc_out                (pc_out),
    .pc4_out               (pc4_out),
    .halt_out              (halt_out),
    .queue_count_out       (queue_count_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: condition not reached within its cycle budget (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder ----------------
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          override_once = 1'b0;
  bit          stray_ack = 1'b0;
  logic [31:0] req_log[$];

  always @(posedge clk) begin
    #1;
    if (stray_ack) begin
      imem_ack_in  = 1'b1;
      imem_data_in = 32'h5555_AAAA;
      stray_ack    = 1'b0;
      wait_cnt     = 0;
    end else if (rst && imem_req_out) begin
      if (wait_cnt >= ack_delay) begin
        imem_ack_in  = 1'b1;
        imem_data_in = override_once ? 32'hDEAD_BEEF : (imem_addr_out ^ 32'hA5A5_0000);
        override_once = 1'b0;
        req_log.push_back(imem_addr_out);
        wait_cnt = 0;
      end else begin
        imem_ack_in = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack_in = 1'b0;
      wait_cnt    = 0;
    end
  end

  // ---------------- reference model ----------------
  // State after the next clock edge, derived from the fetch rules: a queue of
  // buffered words, the next PC to fetch, and whether a fetch is on the bus.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        halt;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] m_fetch_pc, m_req_addr;
  bit          m_out, m_drop, m_halted;

  function automatic void model_reset();
    mq.delete();
    m_fetch_pc = RESET_PC;
    m_req_addr = '0;
    m_out      = 1'b0;
    m_drop     = 1'b0;
    m_halted   = 1'b0;
  endfunction

  function automatic void model_step();
    int n   = mq.size();
    bit ack = imem_ack_in && m_out;
    if (redirect_in_if) begin
      mq.delete();
      m_fetch_pc = redirect_target_in_if;
      m_halted   = 1'b0;
      if (m_out && !ack) m_drop = 1'b1;
      else begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      return;
    end
    if (n > 0 && id_ready_in) void'(mq.pop_front());
    if (m_out) begin
      if (ack) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          mq.push_back('{pc: m_fetch_pc, inst: imem_data_in, halt: 1'b0});
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
        m_out = 1'b0;
      end
    end else if (!m_halted && n < DEPTH) begin
      if (m_fetch_pc[1:0] != 2'b00) begin
        mq.push_back('{pc: m_fetch_pc, inst: NOP, halt: 1'b1});
        m_halted = 1'b1;
      end else begin
        m_out      = 1'b1;
        m_req_addr = m_fetch_pc;
      end
    end
  endfunction

  initial model_reset();

  always @(negedge clk) begin
    if (!rst) model_reset();
    check("cyc_req", 32'(imem_req_out), 32'(m_out));
    check("cyc_count", 32'(queue_count_out), 32'(mq.size()));
    check("cyc_valid", 32'(inst_valid_out), 32'(mq.size() != 0));
    if (m_out) check("cyc_addr", imem_addr_out, m_req_addr);
    if (mq.size() != 0) begin
      check("cyc_inst", inst_out, mq[0].inst);
      check("cyc_pc", pc_out, mq[0].pc);
      check("cyc_pc4", pc4_out, mq[0].pc + 32'd4);
      check("cyc_halt", 32'(halt_out), 32'(mq[0].halt));
    end
    if (rst) model_step();
  end

  // ---------------- helpers (called 2 time units after a rising edge) ----------------
  task automatic do_reset();
    rst = 1'b0;
    redirect_in_if = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    req_log.delete();
  endtask

  task automatic wait_req(input string name, output logic [31:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (imem_req_out) begin ok = 1'b1; break; end
    end
    a = imem_addr_out;
    if (!ok) timeout(name);
  endtask

  task automatic wait_req_addr(input string name, input logic [31:0] addr);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (imem_req_out && imem_addr_out == addr) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_req_with_entry(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (imem_req_out && queue_count_out != 0) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (inst_valid_out) begin ok = 1'b1; break; end
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", 32'(imem_req_out), 32'd0);
    check("rst_addr", imem_addr_out, 32'd0);
    check("rst_valid", 32'(inst_valid_out), 32'd0);
    check("rst_halt", 32'(halt_out), 32'd0);
    check("rst_count", 32'(queue_count_out), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_pc4", pc4_out, 32'd0);

    // Streaming with immediate acks and decode always ready.
    id_ready_in = 1'b1;
    ack_delay   = 0;
    rst         = 1'b1;
    wait_req("s1_first_req", a);
    check("s1_first_addr", a, 32'h0);
    wait_valid("s1_first_valid");
    check("s1_head_pc", pc_out, 32'h0);
    check("s1_head_inst", inst_out, 32'hA5A5_0000);
    check("s1_head_pc4", pc4_out, 32'h4);
    repeat (8) @(posedge clk);
    #2;
    check("s1_addr1", req_log[1], 32'h4);
    check("s1_addr2", req_log[2], 32'h8);

    // Backpressure: FIFO fills to DEPTH, then one pop frees one slot.
    id_ready_in = 1'b0;
    do_reset();
    repeat (20) @(posedge clk);
    #2;
    check("s2_full_count", 32'(queue_count_out), 32'd4);
    check("s2_full_req", 32'(imem_req_out), 32'd0);
    check("s2_req_n", 32'(req_log.size()), 32'd4);
    id_ready_in = 1'b1;
    @(posedge clk); #2;
    id_ready_in = 1'b0;
    check("s2_pop_head", pc_out, 32'h4);
    repeat (6) @(posedge clk);
    #2;
    check("s2_req_n2", 32'(req_log.size()), 32'd5);
    check("s2_refill_addr", req_log[4], 32'h10);
    check("s2_refill_count", 32'(queue_count_out), 32'd4);

    // Redirect while waiting on a slow fetch: the late word is dropped.
    do_reset();
    ack_delay = 3;
    wait_req_addr("s3_wait8", 32'h8);
    req_log.delete();
    override_once         = 1'b1;
    redirect_in_if        = 1'b1;
    redirect_target_in_if = 32'h100;
    @(posedge clk); #2;
    redirect_in_if = 1'b0;
    check("s3_flush_count", 32'(queue_count_out), 32'd0);
    check("s3_flush_valid", 32'(inst_valid_out), 32'd0);
    check("s3_hold_req", 32'(imem_req_out), 32'd1);
    check("s3_hold_addr", imem_addr_out, 32'h8);
    wait_req_addr("s3_req100", 32'h100);
    check("s3_dropped_addr", req_log[0], 32'h8);
    wait_valid("s3_valid100");
    check("s3_head_pc", pc_out, 32'h100);
    check("s3_head_inst", inst_out, 32'h100 ^ 32'hA5A5_0000);

    // Redirect coinciding with an ack and a pop.
    do_reset();
    ack_delay = 0;
    wait_req_with_entry("s4_setup");
    redirect_in_if        = 1'b1;
    redirect_target_in_if = 32'h300;
    id_ready_in           = 1'b1;
    @(posedge clk); #2;
    redirect_in_if = 1'b0;
    id_ready_in    = 1'b0;
    check("s4_count", 32'(queue_count_out), 32'd0);
    check("s4_valid", 32'(inst_valid_out), 32'd0);
    wait_req("s4_next_req", a);
    check("s4_next_addr", a, 32'h300);

    // Misaligned target produces one halt entry and stops fetching.
    redirect_in_if        = 1'b1;
    redirect_target_in_if = 32'h102;
    @(posedge clk); #2;
    redirect_in_if = 1'b0;
    check("s5_valid_after_redirect", 32'(inst_valid_out), 32'd0);
    wait_valid("s5_halt_valid");
    check("s5_halt_pc", pc_out, 32'h102);
    check("s5_halt_inst", inst_out, NOP);
    check("s5_halt_flag", 32'(halt_out), 32'd1);
    check("s5_halt_pc4", pc4_out, 32'h106);
    req_log.delete();
    repeat (10) @(posedge clk);
    #2;
    check("s5_no_reqs", 32'(req_log.size()), 32'd0);
    check("s5_req_low", 32'(imem_req_out), 32'd0);
    check("s5_count", 32'(queue_count_out), 32'd1);
    redirect_in_if        = 1'b1;
    redirect_target_in_if = 32'h200;
    @(posedge clk); #2;
    redirect_in_if = 1'b0;
    wait_req("s5_resume", a);
    check("s5_resume_addr", a, 32'h200);

    // Asynchronous reset in the middle of a request, then a stray ack.
    do_reset();
    ack_delay = 3;
    wait_req_with_entry("s6_setup");
    #1;
    rst = 1'b0;
    #1;
    check("s6_async_req", 32'(imem_req_out), 32'd0);
    check("s6_async_valid", 32'(inst_valid_out), 32'd0);
    check("s6_async_halt", 32'(halt_out), 32'd0);
    check("s6_async_count", 32'(queue_count_out), 32'd0);
    @(posedge clk); #2;
    stray_ack = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    wait_req("s6_first_req", a);
    check("s6_first_addr", a, RESET_PC);
    wait_valid("s6_first_valid");
    check("s6_head_inst", inst_out, 32'hA5A5_0000);
    check("s6_head_pc", pc_out, RESET_PC);

    repeat (4) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
